// File: rtl/mem_access_pkg.sv
// Shared types and the request error decoder for the memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, ILLEGAL = 2'b11} size_e;
  typedef enum logic [1:0] {OK = 2'b00, MISALIGN = 2'b01, RANGE = 2'b10, ILLSIZE = 2'b11} err_e;
  typedef enum logic [1:0] {IDLE = 2'b00, READ = 2'b01, WRITE = 2'b10, RESP = 2'b11} state_e;

  // Priority: illegal size, then misalignment, then word index beyond memory.
  function automatic err_e decode_err(input size_e size, input logic [31:0] addr,
                                      input int unsigned words);
    if (size == ILLEGAL) return ILLSIZE;
    if ((size == HALF && addr[0]) || (size == WORD && addr[1:0] != 2'b00)) return MISALIGN;
    if ({2'b00, addr[31:2]} >= words) return RANGE;
    return OK;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane selection with sign/zero extension for loads, and lane merge for stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merged_o = word_i;
    case (size_i)
      BYTE: begin
        load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merged_o[{offset_i, 3'b000} +: 8] = sdata_i[7:0];
      end
      HALF: begin
        load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        if (offset_i[1]) merged_o[31:16] = sdata_i[15:0];
        else             merged_o[15:0]  = sdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: request FSM, error decode, read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d;
  size_e       size_q, size_d;
  err_e        err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] load_val, merged_val;
  err_e        req_err;

  assign req_err = decode_err(size_e'(req_size), req_addr, MEM_WORDS);

  mem_lane_align u_align (
    .word_i    (mem_rdata),
    .offset_i  (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .sdata_i   (wdata_q),
    .load_o    (load_val),
    .merged_o  (merged_val)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = size_e'(req_size);
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = req_err;
        if (req_err != OK)                          state_d = RESP;
        else if (req_we && size_e'(req_size) == WORD) state_d = WRITE;
        else                                        state_d = READ;
      end
      // Sub-word stores reuse wdata_q to hold the merged word for the WRITE cycle.
      READ: if (we_q) begin
        wdata_d = merged_val;
        state_d = WRITE;
      end else begin
        rdata_d = load_val;
        state_d = RESP;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= OK;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid ? err_q : OK;
  assign mem_re     = rst_n & (state_q == READ);
  assign mem_we     = rst_n & (state_q == WRITE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand-built hold and reset sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic [1:0]  er;
    logic        re;
    logic        wr;
    logic [31:0] wexp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input int lat,
                              input logic [31:0] rd, input logic [1:0] er,
                              input logic re, input logic wr, input logic [31:0] wexp);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd; v.lat = lat;
    v.rd = rd; v.er = er; v.re = re; v.wr = wr; v.wexp = wexp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request from IDLE and follow it to its response (bounded wait).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic [1:0] er,
                        output logic sre, output logic swe, output logic [31:0] wa,
                        output logic [31:0] wdat, output logic clean);
    lat = 0; rd = '0; er = '0; sre = 1'b0; swe = 1'b0; wa = '0; wdat = '0; clean = 1'b1;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    if (!req_ready || mem_re || mem_we) clean = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        if (mem_re || mem_we || req_ready) clean = 1'b0;
        break;
      end
      if (resp_rdata != 32'h0 || resp_err != 2'b00 || req_ready) clean = 1'b0;
      if (mem_re) sre = 1'b1;
      if (mem_we) begin swe = 1'b1; wa = mem_addr; wdat = mem_wdata; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " ready"},  32'(req_ready),  32'h1);
    chk({tag, " rvalid"}, 32'(resp_valid), 32'h0);
    chk({tag, " rdata"},  resp_rdata,      32'h0);
    chk({tag, " err"},    32'(resp_err),   32'h0);
    chk({tag, " re/we"},  {30'h0, mem_re, mem_we}, 32'h0);
    chk({tag, " maddr"},  mem_addr,        32'h0);
    chk({tag, " mwdata"}, mem_wdata,       32'h0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd, wa, wdat;
    logic [1:0]  er;
    logic        sre, swe, clean;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_zero("post-reset");

    //         we  sz    uns addr          wdata         lat rdata         err   re wr wexp
    vt.push_back(mk(1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 2, 32'h0,        2'd0, 0, 1, 32'hDEADBEEF));
    vt.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        2, 32'hDEADBEEF, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(1, 2'd2, 0, 32'h10,  32'h11223344, 2, 32'h0,        2'd0, 0, 1, 32'h11223344));
    vt.push_back(mk(1, 2'd0, 0, 32'h11,  32'h000000A5, 3, 32'h0,        2'd0, 1, 1, 32'h1122A544));
    vt.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        2, 32'h1122A544, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(1, 2'd2, 0, 32'h10,  32'h80FF7F01, 2, 32'h0,        2'd0, 0, 1, 32'h80FF7F01));
    vt.push_back(mk(0, 2'd0, 0, 32'h13,  32'h0,        2, 32'hFFFFFF80, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd0, 1, 32'h13,  32'h0,        2, 32'h00000080, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd1, 0, 32'h12,  32'h0,        2, 32'hFFFF80FF, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        2, 32'h80FF7F01, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd1, 1, 32'h10,  32'h0,        2, 32'h00007F01, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd0, 0, 32'h11,  32'h0,        2, 32'h0000007F, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(1, 2'd0, 0, 32'h10,  32'hFFFFFF77, 3, 32'h0,        2'd0, 1, 1, 32'h80FF7F77));
    vt.push_back(mk(1, 2'd1, 0, 32'h12,  32'h1234BEEF, 3, 32'h0,        2'd0, 1, 1, 32'hBEEF7F77));
    vt.push_back(mk(0, 2'd2, 0, 32'h10,  32'h0,        2, 32'hBEEF7F77, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd1, 0, 32'h11,  32'h0,        1, 32'h0,        2'd1, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd3, 0, 32'h11,  32'h0,        1, 32'h0,        2'd3, 0, 0, 32'h0));
    vt.push_back(mk(1, 2'd3, 0, 32'h10,  32'h55555555, 1, 32'h0,        2'd3, 0, 0, 32'h0));
    vt.push_back(mk(1, 2'd2, 0, 32'h12,  32'h66666666, 1, 32'h0,        2'd1, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd2, 0, 32'h400, 32'h0,        1, 32'h0,        2'd2, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd1, 0, 32'h401, 32'h0,        1, 32'h0,        2'd1, 0, 0, 32'h0));
    vt.push_back(mk(1, 2'd0, 0, 32'h400, 32'h000000AA, 1, 32'h0,        2'd2, 0, 0, 32'h0));
    vt.push_back(mk(0, 2'd0, 0, 32'hFFFFFFFC, 32'h0,   1, 32'h0,        2'd2, 0, 0, 32'h0));
    vt.push_back(mk(1, 2'd2, 0, 32'h3FC, 32'hCAFEF00D, 2, 32'h0,        2'd0, 0, 1, 32'hCAFEF00D));
    vt.push_back(mk(0, 2'd2, 0, 32'h3FC, 32'h0,        2, 32'hCAFEF00D, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(1, 2'd0, 0, 32'h3FF, 32'h0000005A, 3, 32'h0,        2'd0, 1, 1, 32'h5AFEF00D));
    vt.push_back(mk(0, 2'd0, 1, 32'h3FF, 32'h0,        2, 32'h0000005A, 2'd0, 1, 0, 32'h0));
    vt.push_back(mk(0, 2'd1, 0, 32'h3FE, 32'h0,        2, 32'h00005AFE, 2'd0, 1, 0, 32'h0));

    for (int i = 0; i < vt.size(); i++) begin
      do_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].a, vt[i].wd,
             lat, rd, er, sre, swe, wa, wdat, clean);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d err", i), 32'(er), 32'(vt[i].er));
      chk($sformatf("v%0d mem_re seen", i), 32'(sre), 32'(vt[i].re));
      chk($sformatf("v%0d mem_we seen", i), 32'(swe), 32'(vt[i].wr));
      chk($sformatf("v%0d quiet outputs", i), 32'(clean), 32'h1);
      if (vt[i].wr) begin
        chk($sformatf("v%0d mem_addr", i), wa, {vt[i].a[31:2], 2'b00});
        chk($sformatf("v%0d mem_wdata", i), wdat, vt[i].wexp);
      end
    end

    // Held req_valid: SW accepted, then a held LW waits until IDLE returns.
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = '0;
    chk("hold write-cycle ready", 32'(req_ready), 32'h0);
    chk("hold write-cycle mem_we", 32'(mem_we), 32'h1);
    @(posedge clk); #1;
    chk("hold resp ready", 32'(req_ready), 32'h0);
    chk("hold resp valid", 32'(resp_valid), 32'h1);
    @(posedge clk); #1;
    chk("hold idle ready", 32'(req_ready), 32'h1);
    chk("hold idle rvalid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold second read mem_re", 32'(mem_re), 32'h1);
    @(posedge clk); #1;
    chk("hold second resp valid", 32'(resp_valid), 32'h1);
    chk("hold second rdata", resp_rdata, 32'h12345678);
    @(posedge clk); #1;

    // Reset asserted in the WRITE cycle of an SB drops the store and its response.
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, lat, rd, er, sre, swe, wa, wdat, clean);
    chk("rst preload latency", 32'(lat), 32'h2);
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h31; req_wdata = 32'h000000EE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst sb read cycle", 32'(mem_re), 32'h1);
    @(posedge clk); #1;
    chk("rst sb write cycle", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst gates mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    chk("rst no resp", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle_zero("rst release");
    @(posedge clk); #1;
    chk("rst still no resp", 32'(resp_valid), 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, rd, er, sre, swe, wa, wdat, clean);
    chk("rst word unchanged", rd, 32'h11223344);
    chk("rst reload latency", 32'(lat), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
